// File: rtl/pong_pkg.sv
// Shared definitions for the pong score/match controller: FSM encoding,
// default game constants and a constant-evaluable ceil(log2) helper.
package pong_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    HOLD      = 2'd1,
    MATCH_END = 2'd2
  } state_t;

  localparam int DEF_WIN_SCORE    = 11;
  localparam int DEF_GAMES_TO_WIN = 2;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: o_pulse is high while i_level is 1 and its value
// on the previous clock was 0, so a held level produces a single pulse.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/pong_scorekeeper.sv
// Score and match controller: converts collision levels into single points,
// runs win-by-two deuce play and a best-of-N match with a timed hold.
module pong_scorekeeper
  import pong_pkg::*;
#(
  parameter int  SCORE_W      = 4,
  parameter int  WIN_SCORE    = DEF_WIN_SCORE,
  parameter int  WIN_BY_TWO   = 1,
  parameter int  GAMES_TO_WIN = DEF_GAMES_TO_WIN,
  parameter int  HOLD_CYCLES  = 1000,
  localparam int GAMES_W      = clog2(GAMES_TO_WIN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Lftcollision,
  input  logic               Rgtcollision,
  input  logic               new_match,
  output logic [SCORE_W-1:0] Lftscore,
  output logic [SCORE_W-1:0] Rgtscore,
  output logic [GAMES_W-1:0] Lftgames,
  output logic [GAMES_W-1:0] Rgtgames,
  output logic               game_end,
  output logic               deuce,
  output logic               Lftwin,
  output logic               Rgtwin
);

  localparam int HOLD_W = clog2(HOLD_CYCLES + 1);

  localparam logic [SCORE_W:0]   WIN_X      = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [SCORE_W:0]   TWO_X      = (SCORE_W + 1)'(2);
  localparam logic [SCORE_W-1:0] WIN_M1     = SCORE_W'(WIN_SCORE - 1);
  localparam logic [GAMES_W-1:0] GAMES_ONE  = GAMES_W'(1);
  localparam logic [GAMES_W-1:0] GAMES_GOAL = GAMES_W'(GAMES_TO_WIN);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);

  if (WIN_SCORE < 2 || WIN_SCORE > (1 << SCORE_W) - 2 ||
      GAMES_TO_WIN < 1 || HOLD_CYCLES < 1) begin : g_bad_params
    $error("pong_scorekeeper: illegal parameter combination");
  end

  state_t             r_state,  w_nxt_state;
  logic [SCORE_W-1:0] r_lft,    w_nxt_lft;
  logic [SCORE_W-1:0] r_rgt,    w_nxt_rgt;
  logic [GAMES_W-1:0] r_lgames, w_nxt_lgames;
  logic [GAMES_W-1:0] r_rgames, w_nxt_rgames;
  logic [HOLD_W-1:0]  r_hold,   w_nxt_hold;
  logic               r_game_end, w_nxt_game_end;
  logic               r_deuce,    w_nxt_deuce;
  logic               r_lwin,     w_nxt_lwin;
  logic               r_rwin,     w_nxt_rwin;

  logic               w_lft_edge, w_rgt_edge, w_lft_pt, w_rgt_pt;
  logic [SCORE_W:0]   w_cand_l, w_cand_r;
  logic               w_lft_won, w_rgt_won;
  logic [GAMES_W-1:0] w_games_inc;

  edge_pulse u_lft_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (Lftcollision),
    .o_pulse (w_lft_edge)
  );

  edge_pulse u_rgt_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (Rgtcollision),
    .o_pulse (w_rgt_edge)
  );

  // Simultaneous edges cancel: neither side is awarded the point.
  assign w_lft_pt = w_lft_edge & ~w_rgt_edge;
  assign w_rgt_pt = w_rgt_edge & ~w_lft_edge;

  assign w_cand_l  = {1'b0, r_lft} + {{SCORE_W{1'b0}}, w_lft_pt};
  assign w_cand_r  = {1'b0, r_rgt} + {{SCORE_W{1'b0}}, w_rgt_pt};
  assign w_lft_won = w_lft_pt && (w_cand_l >= WIN_X) &&
                     (WIN_BY_TWO == 0 || w_cand_l >= w_cand_r + TWO_X);
  assign w_rgt_won = w_rgt_pt && (w_cand_r >= WIN_X) &&
                     (WIN_BY_TWO == 0 || w_cand_r >= w_cand_l + TWO_X);
  assign w_games_inc = (w_lft_won ? r_lgames : r_rgames) + GAMES_ONE;

  // NOTE: every next-value is defaulted first so no latch is inferred.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_lft      = r_lft;
    w_nxt_rgt      = r_rgt;
    w_nxt_lgames   = r_lgames;
    w_nxt_rgames   = r_rgames;
    w_nxt_hold     = r_hold;
    w_nxt_game_end = 1'b0;
    w_nxt_lwin     = r_lwin;
    w_nxt_rwin     = r_rwin;

    if (new_match) begin
      w_nxt_state  = PLAY;
      w_nxt_lft    = '0;
      w_nxt_rgt    = '0;
      w_nxt_lgames = '0;
      w_nxt_rgames = '0;
      w_nxt_hold   = '0;
      w_nxt_lwin   = 1'b0;
      w_nxt_rwin   = 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_lft_pt || w_rgt_pt) begin
            w_nxt_lft = w_cand_l[SCORE_W-1:0];
            w_nxt_rgt = w_cand_r[SCORE_W-1:0];
            if (w_lft_won || w_rgt_won) begin
              w_nxt_game_end = 1'b1;
              if (w_lft_won) w_nxt_lgames = w_games_inc;
              else           w_nxt_rgames = w_games_inc;
              if (w_games_inc == GAMES_GOAL) begin
                w_nxt_state = MATCH_END;
                w_nxt_lwin  = w_lft_won;
                w_nxt_rwin  = w_rgt_won;
              end else begin
                w_nxt_state = HOLD;
                w_nxt_hold  = HOLD_LOAD;
              end
            end else if (WIN_BY_TWO != 0 && w_cand_l == w_cand_r && w_cand_l >= WIN_X) begin
              w_nxt_lft = WIN_M1;
              w_nxt_rgt = WIN_M1;
            end
          end
        end
        HOLD: begin
          if (r_hold == '0) begin
            w_nxt_state = PLAY;
            w_nxt_lft   = '0;
            w_nxt_rgt   = '0;
          end else begin
            w_nxt_hold = r_hold - HOLD_ONE;
          end
        end
        MATCH_END: ;
        default: w_nxt_state = PLAY;
      endcase
    end
  end

  assign w_nxt_deuce = (WIN_BY_TWO != 0) && (w_nxt_lft >= WIN_M1) &&
                       (w_nxt_rgt >= WIN_M1) && (w_nxt_lft == w_nxt_rgt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PLAY;
      r_lft      <= '0;
      r_rgt      <= '0;
      r_lgames   <= '0;
      r_rgames   <= '0;
      r_hold     <= '0;
      r_game_end <= 1'b0;
      r_deuce    <= 1'b0;
      r_lwin     <= 1'b0;
      r_rwin     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_lft      <= w_nxt_lft;
      r_rgt      <= w_nxt_rgt;
      r_lgames   <= w_nxt_lgames;
      r_rgames   <= w_nxt_rgames;
      r_hold     <= w_nxt_hold;
      r_game_end <= w_nxt_game_end;
      r_deuce    <= w_nxt_deuce;
      r_lwin     <= w_nxt_lwin;
      r_rwin     <= w_nxt_rwin;
    end
  end

  assign Lftscore = r_lft;
  assign Rgtscore = r_rgt;
  assign Lftgames = r_lgames;
  assign Rgtgames = r_rgames;
  assign game_end = r_game_end;
  assign deuce    = r_deuce;
  assign Lftwin   = r_lwin;
  assign Rgtwin   = r_rwin;

endmodule

// File: tb/tb_pong_scorekeeper.sv
// Bench for pong_scorekeeper: two instances (win-by-two to 11, straight to 5)
// compared against a point-by-point behavioural model plus directed scenarios.
module tb_pong_scorekeeper;

  localparam int SW     = 4;
  localparam int A_WIN  = 11;
  localparam int A_B2   = 1;
  localparam int A_GTW  = 2;
  localparam int A_HOLD = 4;
  localparam int B_WIN  = 5;
  localparam int B_B2   = 0;
  localparam int B_GTW  = 2;
  localparam int B_HOLD = 4;

  typedef struct {
    int l; int r; int lg; int rg;
    bit ge; bit deuce; bit lw; bit rw;
    bit prev_l; bit prev_r; bit over;
    int hold_left;
  } model_t;

  logic clk;
  logic rst;
  logic lc_a, rc_a, nm_a, lc_b, rc_b, nm_b;
  logic [SW-1:0] a_lsc, a_rsc, b_lsc, b_rsc;
  logic [1:0]    a_lg, a_rg, b_lg, b_rg;
  logic          a_ge, a_deu, a_lw, a_rw, b_ge, b_deu, b_lw, b_rw;
  logic [15:0]   obs_a, obs_b;

  model_t m_a, m_b;
  int errors = 0;
  int checks = 0;

  pong_scorekeeper #(.SCORE_W(SW), .WIN_SCORE(A_WIN), .WIN_BY_TWO(A_B2),
                     .GAMES_TO_WIN(A_GTW), .HOLD_CYCLES(A_HOLD)) dut_a (
    .clk(clk), .reset(rst), .Lftcollision(lc_a), .Rgtcollision(rc_a),
    .new_match(nm_a), .Lftscore(a_lsc), .Rgtscore(a_rsc), .Lftgames(a_lg),
    .Rgtgames(a_rg), .game_end(a_ge), .deuce(a_deu), .Lftwin(a_lw), .Rgtwin(a_rw)
  );

  pong_scorekeeper #(.SCORE_W(SW), .WIN_SCORE(B_WIN), .WIN_BY_TWO(B_B2),
                     .GAMES_TO_WIN(B_GTW), .HOLD_CYCLES(B_HOLD)) dut_b (
    .clk(clk), .reset(rst), .Lftcollision(lc_b), .Rgtcollision(rc_b),
    .new_match(nm_b), .Lftscore(b_lsc), .Rgtscore(b_rsc), .Lftgames(b_lg),
    .Rgtgames(b_rg), .game_end(b_ge), .deuce(b_deu), .Lftwin(b_lw), .Rgtwin(b_rw)
  );

  assign obs_a = {a_lsc, a_rsc, a_lg, a_rg, a_ge, a_deu, a_lw, a_rw};
  assign obs_b = {b_lsc, b_rsc, b_lg, b_rg, b_ge, b_deu, b_lw, b_rw};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of the game rules, applied to the inputs present at the edge.
  function automatic model_t step(model_t m, bit r_in, bit lc, bit rc, bit nm,
                                  int win, int b2, int gtw, int hc);
    model_t n;
    bit el, er;
    int lead, mine, games;
    if (r_in) begin
      n = '{default: 0};
      return n;
    end
    n = m;
    el = lc && !m.prev_l;
    er = rc && !m.prev_r;
    n.prev_l = lc;
    n.prev_r = rc;
    n.ge = 1'b0;
    if (nm) begin
      n = '{default: 0};
      n.prev_l = lc;
      n.prev_r = rc;
      return n;
    end
    if (m.over) return n;
    if (m.hold_left > 0) begin
      n.hold_left = m.hold_left - 1;
      if (n.hold_left == 0) begin
        n.l = 0;
        n.r = 0;
      end
    end else if (el != er) begin
      if (el) n.l++; else n.r++;
      mine = el ? n.l : n.r;
      lead = el ? n.l - n.r : n.r - n.l;
      if (mine >= win && (b2 == 0 || lead >= 2)) begin
        n.ge = 1'b1;
        if (el) n.lg++; else n.rg++;
        games = el ? n.lg : n.rg;
        if (games == gtw) begin
          n.over = 1'b1;
          if (el) n.lw = 1'b1; else n.rw = 1'b1;
        end else begin
          n.hold_left = hc;
        end
      end else if (b2 != 0 && n.l == n.r && n.l >= win) begin
        n.l = win - 1;
        n.r = win - 1;
      end
    end
    n.deuce = (b2 != 0) && n.l >= win - 1 && n.r >= win - 1 && n.l == n.r;
    return n;
  endfunction

  function automatic logic [15:0] pack(model_t m);
    return {4'(m.l), 4'(m.r), 2'(m.lg), 2'(m.rg), m.ge, m.deuce, m.lw, m.rw};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_a = step(m_a, rst, lc_a, rc_a, nm_a, A_WIN, A_B2, A_GTW, A_HOLD);
    m_b = step(m_b, rst, lc_b, rc_b, nm_b, B_WIN, B_B2, B_GTW, B_HOLD);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lc_a = 1'b0; rc_a = 1'b0; nm_a = 1'b0;
    lc_b = 1'b0; rc_b = 1'b0; nm_b = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_a(bit left);
    if (left) lc_a = 1'b1; else rc_a = 1'b1;
    tick();
    lc_a = 1'b0; rc_a = 1'b0;
    tick();
  endtask

  task automatic pulse_b(bit left);
    if (left) lc_b = 1'b1; else rc_b = 1'b1;
    tick();
    lc_b = 1'b0; rc_b = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_a !== 16'h0000) begin
      errors++; $display("FAIL reset_a: got %h expected %h", obs_a, 16'h0000);
    end
    checks++;
    if (obs_b !== 16'h0000) begin
      errors++; $display("FAIL reset_b: got %h expected %h", obs_b, 16'h0000);
    end
  endtask

  task automatic test_toggle();
    int ends = 0;
    int since = -1;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      lc_a = ~lc_a;
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if (obs_a !== pack(m_a)) begin
          errors++; $display("FAIL toggle_cycle: got %h expected %h", obs_a, pack(m_a));
        end
        if (since >= 0) since++;
        if (a_ge === 1'b1) begin
          ends++;
          since = 0;
          checks++;
          if (a_lsc !== 4'd11 || a_rsc !== 4'd0 || a_lg !== 2'd1) begin
            errors++;
            $display("FAIL toggle_game1: got %0d-%0d games %0d expected 11-0 games 1", a_lsc, a_rsc, a_lg);
          end
        end
        if (since == A_HOLD) begin
          checks++;
          if ({a_lsc, a_rsc} !== 8'h00) begin
            errors++; $display("FAIL toggle_clear: got %0d-%0d expected 0-0", a_lsc, a_rsc);
          end
        end
      end
    end
    checks++;
    if (ends != 1) begin
      errors++; $display("FAIL toggle_game_end_count: got %0d expected 1", ends);
    end
    checks++;
    if (a_lsc !== 4'd4 || a_rsc !== 4'd0 || a_lg !== 2'd1 || a_lw !== 1'b0 || a_rw !== 1'b0) begin
      errors++;
      $display("FAIL toggle_final: got %0d-%0d games %0d win %b%b expected 4-0 games 1 win 00",
               a_lsc, a_rsc, a_lg, a_lw, a_rw);
    end
  endtask

  task automatic test_deuce();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pulse_a(1'b1);
      pulse_a(1'b0);
    end
    checks++;
    if ({a_lsc, a_rsc, a_deu} !== {4'd10, 4'd10, 1'b1}) begin
      errors++; $display("FAIL deuce_10_10: got %0d-%0d deuce %b expected 10-10 deuce 1", a_lsc, a_rsc, a_deu);
    end
    lc_a = 1'b1; tick();
    checks++;
    if ({a_lsc, a_rsc, a_deu, a_ge} !== {4'd11, 4'd10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL deuce_11_10: got %0d-%0d deuce %b end %b expected 11-10 deuce 0 end 0", a_lsc, a_rsc, a_deu, a_ge);
    end
    lc_a = 1'b0; tick();
    rc_a = 1'b1; tick();
    checks++;
    if ({a_lsc, a_rsc, a_deu, a_ge} !== {4'd10, 4'd10, 1'b1, 1'b0}) begin
      errors++; $display("FAIL deuce_collapse: got %0d-%0d deuce %b end %b expected 10-10 deuce 1 end 0", a_lsc, a_rsc, a_deu, a_ge);
    end
    rc_a = 1'b0; tick();
    pulse_a(1'b1);
    lc_a = 1'b1; tick();
    checks++;
    if ({a_lsc, a_rsc, a_ge, a_lg, a_deu} !== {4'd12, 4'd10, 1'b1, 2'd1, 1'b0}) begin
      errors++; $display("FAIL deuce_win: got %0d-%0d end %b games %0d deuce %b expected 12-10 end 1 games 1 deuce 0", a_lsc, a_rsc, a_ge, a_lg, a_deu);
    end
    lc_a = 1'b0; tick();
    checks++;
    if (a_ge !== 1'b0) begin
      errors++; $display("FAIL deuce_end_pulse: got %b expected 0", a_ge);
    end
  endtask

  task automatic test_no_two();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse_b(1'b1);
      pulse_b(1'b0);
    end
    lc_b = 1'b1; tick();
    checks++;
    if ({b_lsc, b_rsc, b_ge, b_lg, b_deu} !== {4'd5, 4'd4, 1'b1, 2'd1, 1'b0}) begin
      errors++; $display("FAIL no_two_win: got %0d-%0d end %b games %0d deuce %b expected 5-4 end 1 games 1 deuce 0", b_lsc, b_rsc, b_ge, b_lg, b_deu);
    end
    lc_b = 1'b0; tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    lc_a = 1'b1; rc_a = 1'b1; tick();
    tick();
    checks++;
    if ({a_lsc, a_rsc, a_ge} !== {4'd0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL simultaneous: got %0d-%0d end %b expected 0-0 end 0", a_lsc, a_rsc, a_ge);
    end
    lc_a = 1'b0; rc_a = 1'b0; tick();
    lc_a = 1'b1;
    repeat (50) tick();
    lc_a = 1'b0; tick();
    checks++;
    if ({a_lsc, a_rsc} !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL held_level: got %0d-%0d expected 1-0", a_lsc, a_rsc);
    end
    rst = 1'b1; lc_a = 1'b1; tick();
    rst = 1'b0; tick(); tick();
    checks++;
    if ({a_lsc, a_rsc} !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL level_at_reset: got %0d-%0d expected 1-0", a_lsc, a_rsc);
    end
    lc_a = 1'b0; tick();
  endtask

  task automatic test_match_end();
    do_reset();
    repeat (11) pulse_a(1'b1);
    repeat (A_HOLD + 2) tick();
    repeat (11) pulse_a(1'b1);
    checks++;
    if (obs_a !== {4'd11, 4'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL match_won: got %h expected %h", obs_a, {4'd11, 4'd0, 2'd2, 2'd0, 4'b0010});
    end
    for (int i = 0; i < 5; i++) begin
      pulse_a(1'b0);
      pulse_a(1'b1);
    end
    checks++;
    if (obs_a !== {4'd11, 4'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL match_frozen: got %h expected %h", obs_a, {4'd11, 4'd0, 2'd2, 2'd0, 4'b0010});
    end
    nm_a = 1'b1; tick();
    nm_a = 1'b0;
    checks++;
    if (obs_a !== 16'h0000) begin
      errors++; $display("FAIL new_match_clear: got %h expected %h", obs_a, 16'h0000);
    end
    pulse_a(1'b0);
    checks++;
    if ({a_lsc, a_rsc} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL new_match_play: got %0d-%0d expected 0-1", a_lsc, a_rsc);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    repeat (10) pulse_a(1'b1);
    lc_a = 1'b1; tick();
    lc_a = 1'b0; tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    checks++;
    if (obs_a !== 16'h0000) begin
      errors++; $display("FAIL hold_reset: got %h expected %h", obs_a, 16'h0000);
    end
    pulse_a(1'b1);
    repeat (10) tick();
    checks++;
    if ({a_lsc, a_rsc, a_ge, a_lg} !== {4'd1, 4'd0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL hold_no_stale: got %0d-%0d end %b games %0d expected 1-0 end 0 games 0", a_lsc, a_rsc, a_ge, a_lg);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      lc_a = ($urandom_range(0, 3) == 0);
      rc_a = ($urandom_range(0, 3) == 0);
      lc_b = ($urandom_range(0, 3) == 0);
      rc_b = ($urandom_range(0, 3) == 0);
      nm_a = ($urandom_range(0, 299) == 0);
      nm_b = ($urandom_range(0, 299) == 0);
      rst  = ($urandom_range(0, 1999) == 0);
      tick();
      checks++;
      if (obs_a !== pack(m_a)) begin
        errors++; $display("FAIL random_a cycle %0d: got %h expected %h", i, obs_a, pack(m_a));
      end
      checks++;
      if (obs_b !== pack(m_b)) begin
        errors++; $display("FAIL random_b cycle %0d: got %h expected %h", i, obs_b, pack(m_b));
      end
    end
    rst = 1'b0; nm_a = 1'b0; nm_b = 1'b0;
    lc_a = 1'b0; rc_a = 1'b0; lc_b = 1'b0; rc_b = 1'b0;
  endtask

  initial begin
    m_a = '{default: 0};
    m_b = '{default: 0};
    rst = 1'b1;
    lc_a = 1'b0; rc_a = 1'b0; nm_a = 1'b0;
    lc_b = 1'b0; rc_b = 1'b0; nm_b = 1'b0;
    test_reset();
    test_toggle();
    test_deuce();
    test_no_two();
    test_simultaneous();
    test_match_end();
    test_reset_mid_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
